seg_scan_controller: RTL and testbench
======================================

SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 1000: clock cycles each digit is driven per slot (legal range >= 1).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 2: anti-ghost blanking cycles before each digit slot (legal range >= 0).
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port Load, input, 1 bit: single-cycle strobe requesting capture of DataIn.
REQ-006 The block SHALL have port DataIn, input, 16 bits: four hex digits; digit i is DataIn[4i+3:4i].
REQ-007 The block SHALL have port DigitEn, input, 4 bits: per-digit enable, sampled live every cycle.
REQ-008 The block SHALL have port Nibble, output, 4 bits: code for the shared LED decoder, with Nibble[3] to decoder In0 (MSB) and Nibble[0] to In3.
REQ-009 The block SHALL have port DigitSel, output, 4 bits: one-hot active-high anode select, all zero while blanked.
REQ-010 The block SHALL have port Pending, output, 1 bit: high while captured data awaits commit.
REQ-011 The block SHALL have port FrameDone, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-012 All outputs SHALL be registered.
REQ-013 The FSM SHALL have states BLANK and SHOW, a 2-bit digit index Idx, and a slot counter Cnt.
REQ-014 In BLANK, DigitSel SHALL be 0000; after BLANK_CYCLES cycles the FSM SHALL enter SHOW with Cnt=0.
REQ-015 If BLANK_CYCLES=0, BLANK SHALL be skipped, giving SHOW to SHOW directly with the next Idx.
REQ-016 In SHOW, DigitSel SHALL equal one-hot(Idx) when DigitEn[Idx]=1, and 0000 otherwise; the slot is still consumed, so brightness stays uniform.
REQ-017 After REFRESH_DIV SHOW cycles, Idx SHALL increment modulo 4 (3 wraps to 0) and the FSM SHALL enter BLANK.
REQ-018 Frame length SHALL be exactly 4*(BLANK_CYCLES+REFRESH_DIV) cycles.
REQ-019 Nibble SHALL equal Display[4*Idx+3:4*Idx], constant across the BLANK and SHOW of one slot, and SHALL update in the first cycle of the slot.
REQ-020 Load=1 SHALL write DataIn into Shadow and set Pending=1 on the next edge; a later Load before commit SHALL overwrite Shadow (last write wins).
REQ-021 Frame boundary SHALL be the transition from the last SHOW cycle of Idx=3 to the first cycle of the Idx=0 slot.
REQ-022 At a frame boundary with Pending=1, the block SHALL set Display<=Shadow and clear Pending; Nibble for digit 0 SHALL show the new data in the same cycle.
REQ-023 When Load coincides with a frame boundary, the old Shadow SHALL be committed, DataIn SHALL be captured into Shadow, and Pending SHALL remain 1.
REQ-024 FrameDone SHALL be high for exactly the first cycle of each Idx=0 slot, except the first slot after reset.
REQ-025 Display SHALL never change mid-frame, so no tearing occurs.

Reset
REQ-026 Reset=1 SHALL immediately force state BLANK, Idx=0, Cnt=0, Display=0, Shadow=0, Pending=0, Nibble=0000, DigitSel=0000, FrameDone=0, regardless of Clk.
REQ-027 Reset asserted mid-slot or mid-commit SHALL discard Shadow and Pending; after deassertion, scanning SHALL restart at digit 0 BLANK.

Verification (REFRESH_DIV=4, BLANK_CYCLES=2)
REQ-028 Scenario: Reset released, DigitEn=1111 -> DigitSel=0000 for cycles 0-1, 0001 for cycles 2-5, 0000 for cycles 6-7, 0010 for cycles 8-11, ..., 1000 for cycles 20-23; FrameDone=1 at cycle 24; Nibble=0000 throughout.
REQ-029 Scenario: Load with DataIn=16'hA5C3 at cycle 10 -> Pending=1 from cycle 11, Nibble unchanged until cycle 24; at cycle 24 Nibble=3 and Pending=0; cycle 30 Nibble=C; cycle 36 Nibble=5; cycle 42 Nibble=A.
REQ-030 Scenario: Loads of 16'h1111 at cycle 5 and 16'h2222 at cycle 9 -> at cycle 24 Display=2222 and Nibble=2.
REQ-031 Scenario: Load of 16'h00F0 on the boundary cycle with Shadow=16'h1234 pending -> Display=1234 at the boundary; Pending stays 1; Display=00F0 at the next boundary.
REQ-032 Scenario: DigitEn=0101 -> DigitSel is 0001 and 0100 in their SHOW slots and 0000 in the digit 1 and digit 3 slots; frame still 24 cycles.
REQ-033 Scenario: Reset pulsed at cycle 15 with Pending=1 -> all outputs zero asynchronously; Pending=0; digit 0 SHOW resumes 2 cycles after release.

Source files
------------

// File: rtl/seg_scan_controller.sv
// Time-multiplexed driver for a four-digit LED display sharing one decoder.
// Scans BLANK/SHOW slots per digit and commits new data only on frame boundaries.
module seg_scan_controller #(
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Load,
  input  logic [15:0] DataIn,
  input  logic [3:0]  DigitEn,
  output logic [3:0]  Nibble,
  output logic [3:0]  DigitSel,
  output logic        Pending,
  output logic        FrameDone
);

  localparam int CNT_RANGE = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W     = (CNT_RANGE > 1) ? $clog2(CNT_RANGE) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [1:0]       idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic [15:0] shadow;
  logic [15:0] display, display_n;
  logic        frame_end;
  logic        commit;

  logic [3:0]  nibble_d;
  logic [3:0]  digit_sel_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register in the
  // design samples pre-edge values, independent of process ordering.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_BLANK;
      idx   <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt + CNT_W'(1);
    unique case (state)
      ST_BLANK: begin
        // With zero blanking this state is only ever visited once, after reset.
        if (BLANK_CYCLES == 0 || cnt == BLANK_LAST) begin
          state_n = ST_SHOW;
          cnt_n   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt == SHOW_LAST) begin
          idx_n   = idx + 2'd1;
          cnt_n   = '0;
          state_n = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
        end
      end
      default: begin
        state_n = ST_BLANK;
        cnt_n   = '0;
      end
    endcase
  end

  assign frame_end = (state == ST_SHOW) && (cnt == SHOW_LAST) && (idx == 2'd3);
  assign commit    = frame_end && Pending;

  // ---------------------------------------------------------------------------
  // Double-buffered display data: Shadow takes writes any time, Display only
  // moves at frame boundaries so a frame never mixes old and new digits.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shadow  <= 16'h0000;
      display <= 16'h0000;
      Pending <= 1'b0;
    end else begin
      if (Load) shadow <= DataIn;
      if (commit) display <= shadow;
      // A Load on the boundary re-arms Pending for the freshly captured word.
      if (Load)           Pending <= 1'b1;
      else if (frame_end) Pending <= 1'b0;
    end
  end

  assign display_n = commit ? shadow : display;

  // ---------------------------------------------------------------------------
  // Output decode from next-state values, so the registered outputs line up
  // with the slot the FSM is entering.
  // ---------------------------------------------------------------------------
  always_comb begin
    nibble_d    = display_n[{idx_n, 2'b00} +: 4];
    digit_sel_d = 4'b0000;
    if (state_n == ST_SHOW && DigitEn[idx_n]) digit_sel_d = 4'b0001 << idx_n;
  end

  // Nibble[3] feeds decoder In0 (its MSB), so the digit value passes straight through.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Nibble    <= 4'b0000;
      DigitSel  <= 4'b0000;
      FrameDone <= 1'b0;
    end else begin
      Nibble    <= nibble_d;
      DigitSel  <= digit_sel_d;
      FrameDone <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: directed scenarios plus random loads/enables,
// checked every cycle against a slot-arithmetic reference model.
module tb_seg_scan_controller;

  localparam int R = 4;
  localparam int B = 2;
  localparam int SLOT = B + R;
  localparam int F = 4 * SLOT;

  logic        Clk;
  logic        Reset;
  logic        Load;
  logic [15:0] DataIn;
  logic [3:0]  DigitEn;
  logic [3:0]  Nibble;
  logic [3:0]  DigitSel;
  logic        Pending;
  logic        FrameDone;

  seg_scan_controller #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (Load),
    .DataIn    (DataIn),
    .DigitEn   (DigitEn),
    .Nibble    (Nibble),
    .DigitSel  (DigitSel),
    .Pending   (Pending),
    .FrameDone (FrameDone)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Reference model: cycle number since reset plus the double-buffer contents.
  int          t;
  logic [15:0] m_shadow;
  logic [15:0] m_display;
  logic        m_pending;
  logic [3:0]  m_en;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic check_cycle();
    int         slot_no, pos, idx;
    logic [3:0] exp_sel;
    logic [3:0] exp_nib;
    slot_no = t / SLOT;
    pos     = t % SLOT;
    idx     = slot_no % 4;
    exp_sel = (pos >= B && m_en[idx]) ? 4'(1 << idx) : 4'b0000;
    exp_nib = m_display[4*idx +: 4];
    check("digit_sel", {12'h0, DigitSel}, {12'h0, exp_sel});
    check("nibble",    {12'h0, Nibble},   {12'h0, exp_nib});
    check("pending",   {15'h0, Pending},  {15'h0, m_pending});
    check("frame_done", {15'h0, FrameDone}, {15'h0, (t > 0 && t % F == 0)});
  endtask

  // One clock cycle: check outputs of cycle t, drive inputs, advance model.
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] en);
    check_cycle();
    Load    = ld;
    DataIn  = d;
    DigitEn = en;
    @(posedge Clk);
    if ((t + 1) % F == 0 && m_pending) begin
      m_display = m_shadow;
      m_pending = 1'b0;
    end
    if (ld) begin
      m_shadow  = d;
      m_pending = 1'b1;
    end
    m_en = en;
    t++;
    @(negedge Clk);
  endtask

  // Asynchronous reset asserted away from the clock edge, released on a negedge.
  task automatic do_reset();
    Load  = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    check("rst_digit_sel", {12'h0, DigitSel}, 16'h0);
    check("rst_nibble",    {12'h0, Nibble},   16'h0);
    check("rst_pending",   {15'h0, Pending},  16'h0);
    check("rst_frame_done", {15'h0, FrameDone}, 16'h0);
    @(negedge Clk);
    Reset     = 1'b0;
    t         = 0;
    m_shadow  = 16'h0;
    m_display = 16'h0;
    m_pending = 1'b0;
    m_en      = DigitEn;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0d: simulation time limit expired", t);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset   = 1'b1;
    Load    = 1'b0;
    DataIn  = 16'h0;
    DigitEn = 4'b1111;
    t       = 0;
    do_reset();

    // Plain scan with all digits enabled, one load mid-frame.
    for (int k = 0; k < 48; k++) begin
      if (t == 2)  check("scan_d0_sel", {12'h0, DigitSel}, 16'h0001);
      if (t == 20) check("scan_d3_sel", {12'h0, DigitSel}, 16'h0008);
      if (t == 11) check("load_pending", {15'h0, Pending}, 16'h1);
      if (t == 23) check("pre_commit_nib", {12'h0, Nibble}, 16'h0);
      if (t == 24) begin
        check("commit_nib0", {12'h0, Nibble}, 16'h3);
        check("commit_pend", {15'h0, Pending}, 16'h0);
        check("first_fd", {15'h0, FrameDone}, 16'h1);
      end
      if (t == 30) check("nib1", {12'h0, Nibble}, 16'hC);
      if (t == 36) check("nib2", {12'h0, Nibble}, 16'h5);
      if (t == 42) check("nib3", {12'h0, Nibble}, 16'hA);
      step(t == 10, 16'hA5C3, 4'b1111);
    end

    // Last write wins, then a load landing exactly on the boundary cycle.
    do_reset();
    for (int k = 0; k < 80; k++) begin
      logic        ld;
      logic [15:0] d;
      ld = 1'b0;
      d  = 16'h0;
      if (t == 5)  begin ld = 1'b1; d = 16'h1111; end
      if (t == 9)  begin ld = 1'b1; d = 16'h2222; end
      if (t == 30) begin ld = 1'b1; d = 16'h1234; end
      if (t == 47) begin ld = 1'b1; d = 16'h00F0; end
      if (t == 24) check("lww_nib", {12'h0, Nibble}, 16'h2);
      if (t == 48) begin
        check("bnd_nib", {12'h0, Nibble}, 16'h4);
        check("bnd_pend", {15'h0, Pending}, 16'h1);
      end
      if (t == 72) check("bnd2_fd", {15'h0, FrameDone}, 16'h1);
      if (t == 78) begin
        check("bnd2_nib1", {12'h0, Nibble}, 16'hF);
        check("bnd2_pend", {15'h0, Pending}, 16'h0);
      end
      step(ld, d, 4'b1111);
    end

    // Partial enables: disabled slots stay dark but keep their time.
    for (int k = 0; k < 30; k++) begin
      if (k > 1 && t % F == 8)  check("en_d1_dark", {12'h0, DigitSel}, 16'h0);
      if (k > 1 && t % F == 14) check("en_d2_on",  {12'h0, DigitSel}, 16'h4);
      step(1'b0, 16'h0, 4'b0101);
    end

    // Reset mid-slot while a word is pending.
    do_reset();
    for (int k = 0; k < 15; k++) step(t == 10, 16'hBEEF, 4'b1111);
    check_cycle();
    check("pre_rst_pend", {15'h0, Pending}, 16'h1);
    do_reset();
    for (int k = 0; k < 30; k++) begin
      if (t == 1) check("post_rst_blank", {12'h0, DigitSel}, 16'h0);
      if (t == 2) check("post_rst_show", {12'h0, DigitSel}, 16'h1);
      if (t == 24) check("post_rst_nib", {12'h0, Nibble}, 16'h0);
      step(1'b0, 16'h0, 4'b1111);
    end

    // Random loads, data and enables.
    for (int k = 0; k < 400; k++) begin
      logic [3:0] en;
      en = (k % 7 == 0) ? 4'($urandom_range(0, 15)) : DigitEn;
      step($urandom_range(0, 9) == 0, 16'($urandom), en);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
